// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared multiply/divide op-code definitions
//
// Purpose: MD op-code constants and op width shared by md_unit, md_calc
//          and the ID-stage decoder. MD_MADD..MD_MSUBU are only acted on
//          when MD_UNIT_MADD_EN is defined; otherwise they decode as no-ops.
package md_unit_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath
//
// Purpose: maps op/operands/{HI,LO} to the 64-bit {HI,LO} result.
//          Optional MADD/MSUB family enabled by macro MD_UNIT_MADD_EN.
// Ports:
//   op          in  4   operation code (md_unit_pkg constants)
//   rs_val      in  32  operand A
//   rt_val      in  32  operand B
//   hilo        in  64  current {HI,LO} (accumulate base)
//   result      out 64  {HI,LO} result for the op
//   div_by_zero out 1   divide op with rt_val == 0
module md_calc
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  input  logic [63:0]        hilo,
  output logic [63:0]        result,
  output logic               div_by_zero
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV) ||
                     (op == MD_MADD) || (op == MD_MSUB);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);

  // The low 64 bits of a 64x64 product of sign/zero-extended operands are
  // exactly the 32x32 signed/unsigned product.
  assign a_ext = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign b_ext = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes then restore signs: truncation toward zero, the
  // remainder follows the dividend, and 0x80000000 / -1 wraps to 0x80000000.
  assign a_neg = is_signed & rs_val[31];
  assign b_neg = is_signed & rt_val[31];
  assign a_mag = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag = b_neg ? (32'd0 - rt_val) : rt_val;

  assign div_by_zero = is_div && (rt_val == 32'd0);

  assign q_mag = (rt_val == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (rt_val == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    result = hilo;
    case (op)
      MD_MULT, MD_MULTU: result = prod;
      MD_DIV,  MD_DIVU:  result = {rem, quot};
`ifdef MD_UNIT_MADD_EN
      MD_MADD, MD_MADDU: result = hilo + prod;
      MD_MSUB, MD_MSUBU: result = hilo - prod;
`endif
      default:           result = hilo;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit with HI/LO and busy
//
// Purpose: owns HI/LO, launches multi-cycle mult/div, holds busy for the
//          op latency and commits the latched result when it ends.
//          Optional MADD/MADDU/MSUB/MSUBU via macro MD_UNIT_MADD_EN.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   start  in  1   launch op this cycle
//   op     in  4   operation code
//   rs_val in  32  operand A
//   rt_val in  32  operand B
//   cancel in  1   suppresses start/mthi/mtlo this cycle
//   busy   out 1   op in flight
//   hi     out 32  HI register
//   lo     out 32  LO register
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  input  logic               cancel,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic [63:0] calc_result;
  logic        calc_dbz;

  md_calc u_md_calc (
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hilo        ({hi_q, lo_q}),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  assign accept = start && !cancel && (state_q == MD_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    dbz_d   = dbz_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          case (op)
            MD_MULT, MD_MULTU
`ifdef MD_UNIT_MADD_EN
            , MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
`endif
            : begin
              pend_d  = calc_result;
              dbz_d   = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_d  = calc_result;
              dbz_d   = calc_dbz;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = MD_RUN;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // Commit on the edge that ends the last busy cycle, so the new
        // HI/LO appear together with busy dropping.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          if (!dbz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard testbench for md_unit
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        strobe;

  int total;
  int bad;

  typedef struct {
    string       name;
    bit          snap;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    bit          chk_cyc;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input bit s, input logic [31:0] h,
                      input logic [31:0] l, input int cyc, input bit cc);
    exp_t e;
    e.name = nm; e.snap = s; e.hi = h; e.lo = l; e.cycles = cyc; e.chk_cyc = cc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP; cancel = 1'b0;
  endtask

  task automatic snap(input string nm, input logic [31:0] h, input logic [31:0] l);
    push(nm, 1'b1, h, l, 0, 1'b0);
    @(posedge clk); #1; strobe = 1'b1;
    @(posedge clk); #1; strobe = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still 1 after 64 cycles, want 0", nm);
    end
  endtask

  // Monitor: pops an expectation whenever busy falls (op completion) or the
  // stimulus strobes a snapshot of the idle state.
  initial begin : monitor
    int   run;
    bit   prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) run = prev ? run + 1 : 1;
      if (prev && !busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: busy fell with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_kind"}, 32'(e.snap), 32'd0);
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          if (e.chk_cyc) chk({e.name, "_cycles"}, 32'(run), 32'(e.cycles));
        end
      end
      if (strobe) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_snap: strobe with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_kind"}, 32'(e.snap), 32'd1);
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy"}, 32'(busy), 32'd0);
        end
      end
      prev = busy;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    total = 0; bad = 0;
    reset = 1'b0; start = 1'b0; op = MD_NOP; rs_val = '0; rt_val = '0;
    cancel = 1'b0; strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    snap("reset", 32'h0, 32'h0);

    // Reset mid-run clears HI/LO and busy immediately
    issue(MD_MTHI, 32'h55, 32'h0, 1'b0);
    snap("mthi55", 32'h55, 32'h0);
    push("rst_mid", 1'b0, 32'h0, 32'h0, 0, 1'b0);
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    snap("post_rst", 32'h0, 32'h0);

    issue(MD_MTLO, 32'h1234, 32'h0, 1'b0);
    snap("mtlo", 32'h0, 32'h0000_1234);

    push("mult_m1x2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b1);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_idle("mult_m1x2");

    push("multu", 1'b0, 32'h1, 32'hFFFF_FFFE, 5, 1'b1);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_idle("multu");

    push("div_m7_2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_idle("div_m7_2");

    push("divu_7_2", 1'b0, 32'h1, 32'h3, 10, 1'b1);
    issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle("divu_7_2");

    issue(MD_MTHI, 32'hAA, 32'h0, 1'b0);
    issue(MD_MTLO, 32'hBB, 32'h0, 1'b0);
    snap("preload", 32'hAA, 32'hBB);

    push("divu_by0", 1'b0, 32'hAA, 32'hBB, 10, 1'b1);
    issue(MD_DIVU, 32'd5, 32'd0, 1'b0);
    wait_idle("divu_by0");

    push("div_by0", 1'b0, 32'hAA, 32'hBB, 10, 1'b1);
    issue(MD_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);
    wait_idle("div_by0");

    push("div_ovf", 1'b0, 32'h0, 32'h8000_0000, 10, 1'b1);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf");

    // Second start while busy and cancel during RUN must be harmless
    push("mult_ign", 1'b0, 32'h3, 32'h0, 5, 1'b1);
    issue(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0);
    issue(MD_DIV, 32'd9, 32'd3, 1'b0);
    #0 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    wait_idle("mult_ign");
    repeat (3) @(posedge clk);
    snap("after_ign", 32'h3, 32'h0);

    issue(MD_MTHI, 32'd5, 32'h0, 1'b1);
    snap("mthi_cancel", 32'h3, 32'h0);
    issue(MD_MULT, 32'd5, 32'd5, 1'b1);
    snap("mult_cancel", 32'h3, 32'h0);
    issue(4'hF, 32'd5, 32'd5, 1'b0);
    snap("bad_op", 32'h3, 32'h0);

    issue(MD_MTHI, 32'd0, 32'h0, 1'b0);
    issue(MD_MTLO, 32'd10, 32'h0, 1'b0);
    snap("madd_base", 32'h0, 32'd10);
`ifdef MD_UNIT_MADD_EN
    push("madd", 1'b0, 32'h0, 32'd22, 5, 1'b1);
    issue(MD_MADD, 32'd3, 32'd4, 1'b0);
    wait_idle("madd");
    push("msubu", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5, 1'b1);
    issue(MD_MSUBU, 32'd5, 32'd5, 1'b0);
    wait_idle("msubu");
`else
    issue(MD_MADD, 32'd3, 32'd4, 1'b0);
    snap("madd_off", 32'h0, 32'd10);
    issue(MD_MSUBU, 32'd5, 32'd5, 1'b0);
    snap("msubu_off", 32'h0, 32'd10);
`endif

    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
